// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the bubble instruction.
// No logic; no latency or backpressure.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID instruction's sources and the EX load's destination.
// Purely combinational, zero latency; no backpressure of its own.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);

    // Register 0 is hardwired zero, so a load into it never creates a dependency.
    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_use_rs && (id_rs == ex_rd)) ||
                       (id_use_rt && (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes, data-memory wait and timeout.
// Outputs combinational from state and inputs (zero latency); a pending memory access freezes every stage.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ma_mem_req,
    input  logic             ma_mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exma_en,
    output logic             mawb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             wb_valid,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_busy;
    logic              issue;
    logic              wb_valid_q;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    assign mem_busy = ma_mem_req && !ma_mem_ready;

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exma_en    = 1'b0;
        mawb_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        case (state)
            RUN: begin
                if (mem_busy) state_nxt = MWAIT;
                else          issue     = 1'b1;
            end
            MWAIT: begin
                // A ready on the timeout cycle still completes the access.
                if (ma_mem_ready) begin
                    state_nxt = RUN;
                    issue     = 1'b1;
                end else if (wait_cnt >= WAIT_LAST) begin
                    state_nxt = ERR;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase

        if (issue) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
            idex_en = 1'b1;
            exma_en = 1'b1;
            mawb_en = 1'b1;
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exma_en    = 1'b0;
            mawb_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // The RUN cycle that detects the miss is the first wait cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            wb_valid_q <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            wb_valid_q <= mawb_en;
            if (state_nxt == MWAIT)
                wait_cnt <= (state == RUN) ? WAIT_W'(1) : wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign wb_valid = wb_valid_q;
    assign mem_err  = (state == ERR);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued when inputs are driven
// and popped when outputs are sampled mid-cycle; a second instance has a 4-bit stall counter.
module tb_pipe_ctrl;

    localparam logic [6:0] V_RUN   = 7'b11111_00;
    localparam logic [6:0] V_LU    = 7'b00111_01;
    localparam logic [6:0] V_BR    = 7'b11111_11;
    localparam logic [6:0] V_FRZ   = 7'b00000_00;
    localparam logic [6:0] V_RST   = 7'b00000_11;

    logic       clk, rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_is_load, ex_branch_taken, ma_mem_req, ma_mem_ready;

    logic        pc_en, ifid_en, idex_en, exma_en, mawb_en, ifid_flush, idex_flush, wb_valid, mem_err;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exma_en, s_mawb_en, s_ifid_flush, s_idex_flush;
    logic        s_wb_valid, s_mem_err;
    logic [3:0]  s_stall_cnt;
    logic [6:0]  ctrl, s_ctrl;

    int          n_tests, n_fail;
    logic [6:0]  sb[$];
    logic [15:0] exp_stall;
    logic [3:0]  exp_sat;
    logic        exp_wb;

    assign ctrl   = {pc_en, ifid_en, idex_en, exma_en, mawb_en, ifid_flush, idex_flush};
    assign s_ctrl = {s_pc_en, s_ifid_en, s_idex_en, s_exma_en, s_mawb_en, s_ifid_flush, s_idex_flush};

    pipe_ctrl u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ma_mem_req(ma_mem_req), .ma_mem_ready(ma_mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exma_en(exma_en), .mawb_en(mawb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .wb_valid(wb_valid), .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ma_mem_req(ma_mem_req), .ma_mem_ready(ma_mem_ready),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exma_en(s_exma_en),
        .mawb_en(s_mawb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .wb_valid(s_wb_valid), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
    task automatic step(input string tag, input logic ld, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt, input logic br,
                        input logic mreq, input logic mrdy, input logic [6:0] exp);
        logic [6:0] e;
        ex_is_load = ld; ex_rd = rd; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_branch_taken = br; ma_mem_req = mreq; ma_mem_ready = mrdy;
        sb.push_back(exp);
        #2;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ctrl"}, 32'(ctrl), 32'(e));
            chk({tag, "_sat_ctrl"}, 32'(s_ctrl), 32'(e));
            chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(exp_wb));
            chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
            chk({tag, "_sat_stall"}, 32'(s_stall_cnt), 32'(exp_sat));
            if (!e[6]) begin
                if (exp_stall != 16'hFFFF) exp_stall++;
                if (exp_sat != 4'hF) exp_sat++;
            end
            exp_wb = e[2];
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic [6:0] exp);
        step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic mem(input string tag, input logic mrdy, input logic [6:0] exp);
        step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, mrdy, exp);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        ex_is_load = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_branch_taken = 0; ma_mem_req = 0; ma_mem_ready = 0;
        sb.push_back(V_RST);
        #1;
        chk({tag, "_ctrl"}, 32'(ctrl), 32'(sb.pop_front()));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, "_sat_stall"}, 32'(s_stall_cnt), 32'd0);
        chk({tag, "_mem_err"}, 32'(mem_err), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 0; exp_sat = 0; exp_wb = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        do_reset("reset");

        idle("idle0", V_RUN);
        idle("idle1", V_RUN);

        // Load-use on rs, then rt; non-matching or unused operands must not stall.
        step("lu_rs", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU);
        idle("lu_rs_after", V_RUN);
        chk("lu_one_stall", 32'(stall_cnt), 32'd1);
        step("lu_rt", 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_LU);
        step("lu_unused", 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
        step("not_load", 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN);
        step("rd_zero", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN);

        step("br_lu", 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, V_BR);
        step("br_only", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_BR);
        idle("idle2", V_RUN);

        // Three-cycle memory wait.
        do_reset("reset_w3");
        for (int i = 0; i < 3; i++) mem("wait3", 1'b0, V_FRZ);
        mem("wait3_rel", 1'b1, V_RUN);
        idle("wait3_after", V_RUN);
        chk("wait3_mem_err", 32'(mem_err), 32'd0);
        chk("wait3_stall_cnt", 32'(stall_cnt), 32'd3);

        // Release with pending branch, then with pending load-use; miss outranks hazard.
        mem("wbr", 1'b0, V_FRZ);
        mem("wbr", 1'b0, V_FRZ);
        step("wbr_rel", 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, V_BR);
        step("wlu_miss", 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ);
        step("wlu_rel", 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, V_LU);
        mem("hit", 1'b1, V_RUN);

        // Ready on the timeout cycle wins.
        for (int i = 0; i < 15; i++) mem("tmo_edge", 1'b0, V_FRZ);
        mem("tmo_edge_rel", 1'b1, V_RUN);
        idle("tmo_edge_after", V_RUN);
        chk("tmo_edge_mem_err", 32'(mem_err), 32'd0);

        // Full timeout into ERR; ERR ignores ready and only reset leaves it.
        do_reset("reset_tmo");
        for (int i = 0; i < 15; i++) mem("tmo", 1'b0, V_FRZ);
        chk("tmo_pre_err", 32'(mem_err), 32'd0);
        mem("tmo_last", 1'b0, V_FRZ);
        chk("tmo_err", 32'(mem_err), 32'd1);
        chk("tmo_sat_err", 32'(s_mem_err), 32'd1);
        for (int i = 0; i < 3; i++) mem("err_hold", 1'b0, V_FRZ);
        mem("err_rdy", 1'b1, V_FRZ);
        chk("err_stay", 32'(mem_err), 32'd1);
        chk("err_stall_cnt", 32'(stall_cnt), 32'd20);
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'd15);
        chk("err_wb_valid", 32'(wb_valid), 32'd0);
        do_reset("reset_err");
        idle("post_err", V_RUN);
        idle("post_err2", V_RUN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter REG_W, default 5, SHALL set the register-specifier width.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of data-memory wait cycles before an error is raised.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port id_rs / id_rt, input, REG_W each: source registers of the instruction in ID.
REQ-007 Port id_use_rs / id_use_rt, input, 1 each: the ID instruction reads rs / rt.
REQ-008 Port ex_is_load, input, 1: the instruction in EX is a load.
REQ-009 Port ex_rd, input, REG_W: destination register of the EX instruction.
REQ-010 Port ex_branch_taken, input, 1: the EX instruction redirects the PC this cycle.
REQ-011 Port ma_mem_req, input, 1: the MA instruction accesses data memory.
REQ-012 Port ma_mem_ready, input, 1: data memory has completed the MA access.
REQ-013 Port pc_en / ifid_en / idex_en / exma_en / mawb_en, output, 1 each: load enables for the PC and the four pipeline registers.
REQ-014 Port ifid_flush / idex_flush, output, 1 each: load a bubble (NOP, IR=0) into that register.
REQ-015 Port wb_valid, output, 1: the MA/WB register holds a valid instruction whose result may be written back.
REQ-016 Port mem_err, output, 1: sticky memory-timeout error.
REQ-017 Port stall_cnt, output, CNT_W: saturating count of stalled cycles.

Function
REQ-018 The FSM SHALL have the states RUN, MWAIT and ERR.
REQ-019 In RUN with no hazard, all enables SHALL be 1, both flushes 0, and wb_valid SHALL be 1 on the following cycle.
REQ-020 Load-use hazard = ex_is_load && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
REQ-021 On a load-use hazard in RUN, pc_en and ifid_en SHALL be 0, idex_flush SHALL be 1, and exma_en and mawb_en SHALL be 1, inserting exactly one bubble.
REQ-022 On ex_branch_taken in RUN, ifid_flush and idex_flush SHALL be 1 with pc_en 1; branch takes priority over load-use in the same cycle.
REQ-023 In RUN with ma_mem_req && !ma_mem_ready, the FSM SHALL enter MWAIT and all enables SHALL be 0 in that cycle; this takes priority over branch and load-use.
REQ-024 In MWAIT, all enables SHALL be 0, flushes 0 and wb_valid 0; a wait counter SHALL increment each cycle.
REQ-025 In MWAIT, ma_mem_ready=1 SHALL release all enables in that same cycle and return to RUN; pending branch and load-use conditions SHALL then be evaluated as in RUN.
REQ-026 If the wait counter reaches TIMEOUT-1 without ma_mem_ready, the FSM SHALL enter ERR and set mem_err.
REQ-027 In ERR, all enables SHALL be 0 and wb_valid 0; the FSM SHALL leave ERR only on reset.
REQ-028 A ready arriving on the same cycle as the timeout SHALL win: the FSM returns to RUN with no error.
REQ-029 stall_cnt SHALL increment in every cycle with pc_en=0, saturate at all-ones, and not wrap.
REQ-030 Outputs SHALL be combinational from the state and current inputs; no added latency.

Reset
REQ-031 Asserting rst SHALL immediately force state RUN, wait counter 0, stall_cnt 0, mem_err 0 and wb_valid 0.
REQ-032 While rst is high, all enables SHALL be 0 and both flushes SHALL be 1.
REQ-033 Reset asserted in MWAIT or ERR SHALL abandon the access without further output activity.

Structure
REQ-034 State encodings and the NOP constant (32'h0) SHALL live in the shared package pipe_pkg.
REQ-035 The hazard comparator SHALL be the sub-module hazard_detect (pure combinational); the FSM and counters stay in pipe_ctrl.

Verification
REQ-036 ex_is_load=1, ex_rd=5, id_rs=5, id_use_rs=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-037 Same as REQ-036 but ex_rd=0 -> no stall; all enables stay 1.
REQ-038 ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-039 ma_mem_req=1 with ma_mem_ready low for 3 cycles, then high -> enables 0 for 3 cycles, RUN on the 4th, mem_err=0, stall_cnt=3.
REQ-040 ma_mem_ready low for 16 cycles -> ERR, mem_err=1, enables stay 0; then rst pulse -> RUN with all counters 0.
REQ-041 CNT_W=4 with 20 forced stall cycles -> stall_cnt holds at 15.
